// File: rtl/move_collision_unit.sv
// Round-robin one-step move checker for maze sprites: computes the target tile
// with horizontal tunnel wrap, probes the wall map and reports accept/reject per sprite.
module move_collision_unit #(
    parameter int N_CH  = 4,
    parameter int STEP  = 8,
    parameter int X_MAX = 640,
    parameter int Y_MAX = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      req,
    input  logic [2*N_CH-1:0]    dir,
    input  logic [XW*N_CH-1:0]   pos_x,
    input  logic [YW*N_CH-1:0]   pos_y,
    output logic                 map_rd,
    output logic [XW-1:0]        map_x,
    output logic [YW-1:0]        map_y,
    input  logic                 map_wall,
    output logic [N_CH-1:0]      done,
    output logic [N_CH-1:0]      ok,
    output logic [XW*N_CH-1:0]   new_x,
    output logic [YW*N_CH-1:0]   new_y,
    output logic                 busy
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [XW:0] STEP_X  = (XW+1)'(STEP);
    localparam logic [XW:0] X_MAX_X = (XW+1)'(X_MAX);
    localparam logic [YW:0] STEP_Y  = (YW+1)'(STEP);
    localparam logic [YW:0] Y_MAX_Y = (YW+1)'(Y_MAX);

    typedef enum logic [2:0] {IDLE, CALC, PROBE, WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   ptr_reg, ch_reg;
    logic [1:0]      dir_reg;
    logic [XW-1:0]   px_reg, tx_reg;
    logic [YW-1:0]   py_reg, ty_reg;
    logic            rej_reg;
    logic            map_rd_reg;
    logic [XW-1:0]   map_x_reg;
    logic [YW-1:0]   map_y_reg;
    logic [N_CH-1:0] done_reg, ok_reg;
    logic [XW-1:0]   new_x_reg [N_CH];
    logic [YW-1:0]   new_y_reg [N_CH];

    logic [1:0]      dir_ch [N_CH];
    logic [XW-1:0]   px_ch  [N_CH];
    logic [YW-1:0]   py_ch  [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign dir_ch[gi] = dir[2*gi +: 2];
            assign px_ch[gi]  = pos_x[XW*gi +: XW];
            assign py_ch[gi]  = pos_y[YW*gi +: YW];
            assign new_x[XW*gi +: XW] = new_x_reg[gi];
            assign new_y[YW*gi +: YW] = new_y_reg[gi];
        end
    endgenerate

    assign map_rd = map_rd_reg;
    assign map_x  = map_x_reg;
    assign map_y  = map_y_reg;
    assign done   = done_reg;
    assign ok     = ok_reg;
    assign busy   = (state_reg != IDLE);

    // Round-robin grant: scan far-to-near so the nearest set bit after ptr wins.
    logic          grant_valid;
    logic [CW-1:0] grant_idx;
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = N_CH; i >= 1; i--) begin
            if (req[CW'((int'(ptr_reg) + i) % N_CH)]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'((int'(ptr_reg) + i) % N_CH);
            end
        end
    end

    // Target computation, one bit wider than the coordinates so nothing truncates.
    logic [XW:0] px_w, x_sum, tx_c;
    logic [YW:0] py_w, y_sum, ty_c;
    logic        rej_c;
    always_comb begin
        px_w  = {1'b0, px_reg};
        py_w  = {1'b0, py_reg};
        x_sum = px_w + STEP_X;
        y_sum = py_w + STEP_Y;
        tx_c  = px_w;
        ty_c  = py_w;
        rej_c = (px_w >= X_MAX_X) || (py_w >= Y_MAX_Y);
        case (dir_reg)
            2'b00: begin
                ty_c = py_w - STEP_Y;
                if (py_w < STEP_Y) rej_c = 1'b1;
            end
            2'b01: begin
                ty_c = y_sum;
                if (y_sum >= Y_MAX_Y) rej_c = 1'b1;
            end
            2'b10: tx_c = (px_w >= STEP_X) ? (px_w - STEP_X) : (px_w + X_MAX_X - STEP_X);
            default: tx_c = (x_sum < X_MAX_X) ? x_sum : (x_sum - X_MAX_X);
        endcase
        // A target that cannot be represented in the coordinate width is never legal.
        if (tx_c[XW] || ty_c[YW]) rej_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Rejected moves still walk PROBE/WAIT (with the map untouched) so that
    // every completion has the same latency.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = CALC;
            CALC:    state_next = PROBE;
            PROBE:   state_next = WAIT;
            WAIT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg    <= CW'(N_CH - 1);
            ch_reg     <= '0;
            dir_reg    <= '0;
            px_reg     <= '0;
            py_reg     <= '0;
            tx_reg     <= '0;
            ty_reg     <= '0;
            rej_reg    <= 1'b0;
            map_rd_reg <= 1'b0;
            map_x_reg  <= '0;
            map_y_reg  <= '0;
            done_reg   <= '0;
            ok_reg     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                new_x_reg[i] <= '0;
                new_y_reg[i] <= '0;
            end
        end else begin
            map_rd_reg <= 1'b0;
            done_reg   <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        ch_reg  <= grant_idx;
                        ptr_reg <= grant_idx;
                        dir_reg <= dir_ch[grant_idx];
                        px_reg  <= px_ch[grant_idx];
                        py_reg  <= py_ch[grant_idx];
                    end
                end
                CALC: begin
                    tx_reg  <= tx_c[XW-1:0];
                    ty_reg  <= ty_c[YW-1:0];
                    rej_reg <= rej_c;
                    if (!rej_c) begin
                        map_rd_reg <= 1'b1;
                        map_x_reg  <= tx_c[XW-1:0];
                        map_y_reg  <= ty_c[YW-1:0];
                    end
                end
                WAIT: begin
                    // map_wall answers the PROBE-cycle read; results land as DONE begins.
                    done_reg[ch_reg] <= 1'b1;
                    ok_reg[ch_reg]   <= ~(rej_reg | map_wall);
                    if (rej_reg || map_wall) begin
                        new_x_reg[ch_reg] <= px_reg;
                        new_y_reg[ch_reg] <= py_reg;
                    end else begin
                        new_x_reg[ch_reg] <= tx_reg;
                        new_y_reg[ch_reg] <= ty_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_move_collision_unit.sv
// Directed bench for move_collision_unit: single moves, tunnel wrap, bounds,
// reset abort and round-robin arbitration, each against hand-computed values.
module tb_move_collision_unit;

    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [2*N-1:0]    dir = '0;
    logic [XW*N-1:0]   pos_x = '0;
    logic [YW*N-1:0]   pos_y = '0;
    logic              map_rd;
    logic [XW-1:0]     map_x;
    logic [YW-1:0]     map_y;
    logic              map_wall = 1'b0;
    logic [N-1:0]      done, ok;
    logic [XW*N-1:0]   new_x;
    logic [YW*N-1:0]   new_y;
    logic              busy;

    int checks = 0;
    int failures = 0;

    move_collision_unit #(.N_CH(N), .STEP(8), .X_MAX(640), .Y_MAX(480), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir), .pos_x(pos_x), .pos_y(pos_y),
        .map_rd(map_rd), .map_x(map_x), .map_y(map_y), .map_wall(map_wall),
        .done(done), .ok(ok), .new_x(new_x), .new_y(new_y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One move on channel ch; req raised at a negedge so the next posedge samples it.
    task automatic run_move(input string name, input int ch, input logic [1:0] d,
                            input int x, input int y, input logic wall,
                            input int exp_ok, input int ex, input int ey,
                            input int exp_probe, input int mx, input int my);
        int cyc = 0, rd_cnt = 0, rd_cyc = 0, done_cyc = 0;
        int mx_s = 0, my_s = 0;
        @(negedge clk);
        dir[2*ch +: 2]    = d;
        pos_x[XW*ch +: XW] = XW'(x);
        pos_y[YW*ch +: YW] = YW'(y);
        map_wall          = wall;
        req[ch]           = 1'b1;
        while (done_cyc == 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (map_rd) begin
                rd_cnt++;
                rd_cyc = cyc;
                mx_s   = int'(map_x);
                my_s   = int'(map_y);
            end
            if (done[ch]) done_cyc = cyc;
        end
        check({name, "_done_latency"}, done_cyc, 4);
        check({name, "_ok"}, int'(ok[ch]), exp_ok);
        check({name, "_new_x"}, int'(new_x[XW*ch +: XW]), ex);
        check({name, "_new_y"}, int'(new_y[YW*ch +: YW]), ey);
        check({name, "_map_rd_count"}, rd_cnt, exp_probe);
        if (exp_probe != 0) begin
            check({name, "_map_rd_cycle"}, rd_cyc, 2);
            check({name, "_map_x"}, mx_s, mx);
            check({name, "_map_y"}, my_s, my);
        end
        @(negedge clk);
        req[ch] = 1'b0;
        @(posedge clk); #1;
        check({name, "_done_single"}, int'(done), 0);
        check({name, "_idle"}, int'(busy), 0);
        $display("move %s ch=%0d dir=%0d pos=(%0d,%0d) -> ok=%0d new=(%0d,%0d)",
                 name, ch, d, x, y, ok[ch], new_x[XW*ch +: XW], new_y[YW*ch +: YW]);
    endtask

    initial begin
        int cyc, n, last, ch_seen;

        repeat (2) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0);
        check("rst_ok", int'(ok), 0);
        check("rst_new_x", int'(new_x), 0);
        check("rst_new_y", int'(new_y), 0);
        check("rst_map_rd", int'(map_rd), 0);
        check("rst_map_x", int'(map_x), 0);
        check("rst_map_y", int'(map_y), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b1;

        run_move("right_free", 0, 2'b11, 100, 200, 1'b0, 1, 108, 200, 1, 108, 200);
        run_move("right_wall", 0, 2'b11, 100, 200, 1'b1, 0, 100, 200, 1, 108, 200);
        run_move("tunnel_left", 0, 2'b10, 4, 240, 1'b0, 1, 636, 240, 1, 636, 240);
        run_move("tunnel_right", 0, 2'b11, 636, 240, 1'b0, 1, 4, 240, 1, 4, 240);
        run_move("up_bound", 0, 2'b00, 320, 4, 1'b0, 0, 320, 4, 0, 0, 0);
        check("map_x_held", int'(map_x), 4);
        check("map_y_held", int'(map_y), 240);
        run_move("down_bound", 0, 2'b01, 320, 472, 1'b0, 0, 320, 472, 0, 0, 0);
        run_move("down_free", 0, 2'b01, 320, 100, 1'b0, 1, 320, 108, 1, 320, 108);
        run_move("x_out_range", 0, 2'b11, 650, 100, 1'b0, 0, 650, 100, 0, 0, 0);
        run_move("up_to_zero", 0, 2'b00, 320, 8, 1'b0, 1, 320, 0, 1, 320, 0);
        run_move("ch1_right", 1, 2'b11, 200, 50, 1'b0, 1, 208, 50, 1, 208, 50);
        check("ch0_ok_kept", int'(ok[0]), 1);
        check("ch0_new_x_kept", int'(new_x[0 +: XW]), 320);
        check("ch0_new_y_kept", int'(new_y[0 +: YW]), 0);

        // Reset while the channel-2 move sits in WAIT.
        @(negedge clk);
        dir[4 +: 2]    = 2'b11;
        pos_x[20 +: XW] = XW'(300);
        pos_y[18 +: YW] = YW'(300);
        map_wall       = 1'b0;
        req[2]         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ok", int'(ok), 0);
        check("reset_new_x", int'(new_x), 0);
        check("reset_new_y", int'(new_y), 0);
        check("reset_map_rd", int'(map_rd), 0);
        check("reset_map_x", int'(map_x), 0);
        check("reset_map_y", int'(map_y), 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_no_done", int'(done), 0);
        $display("reset asserted during WAIT: busy=%0d done=%0d", busy, done);
        req = '0;
        @(negedge clk);
        rst = 1'b1;

        // All four channels request continuously.
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            dir[2*i +: 2]     = 2'b11;
            pos_x[XW*i +: XW] = XW'(100 + 50*i);
            pos_y[YW*i +: YW] = YW'(60);
        end
        req = '1;
        cyc = 0; n = 0; last = 0;
        while (n < 8 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done != '0) begin
                ch_seen = -1;
                for (int i = 0; i < N; i++) if (done[i]) ch_seen = i;
                check("arb_channel", ch_seen, n % N);
                check("arb_gap", cyc - last, (n == 0) ? 4 : 5);
                if (ch_seen >= 0)
                    check("arb_new_x", int'(new_x[XW*ch_seen +: XW]), 108 + 50*ch_seen);
                $display("arbitration done #%0d ch=%0d at cycle %0d", n, ch_seen, cyc);
                last = cyc;
                n++;
            end
        end
        check("arb_count", n, 8);
        @(negedge clk);
        req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
